// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single shared memory port.
// Data master has fixed priority over the instruction master. A stalled request
// (mem_req without mem_addr_ok) locks the grant to that master until accepted.
// An owner FIFO records who issued each accepted request so in-order responses
// can be steered back to the right master.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(MAX_OUT) + 1;
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic          r_lock;
    logic          r_lock_data;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_owner [MAX_OUT];

    logic          w_sel_data;
    logic          w_sel_req;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_head_data;

    // Pointer advance with explicit wrap so MAX_OUT=1 also behaves.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUT - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Grant selection, request gating and handshake steering.
    always_comb begin
        w_sel_data   = r_lock ? r_lock_data : data_req;
        w_sel_req    = w_sel_data ? data_req : inst_req;
        w_full       = (r_count == CW'(MAX_OUT));
        mem_req      = w_sel_req & ~w_full & ~rst;
        w_push       = mem_req & mem_addr_ok;
        // A response with nothing outstanding is dropped without effect.
        w_pop        = mem_data_ok & (r_count != '0) & ~rst;
        w_head_data  = r_owner[r_rptr];

        inst_addr_ok = w_push & ~w_sel_data;
        data_addr_ok = w_push & w_sel_data;
        inst_data_ok = w_pop & ~w_head_data;
        data_data_ok = w_pop & w_head_data;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Request payload mux; instruction fetches never write.
    always_comb begin
        if (w_sel_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = 1'b0;
            mem_size  = inst_size;
            mem_wstrb = 4'h0;
            mem_addr  = inst_addr;
            mem_wdata = 32'h0;
        end
    end

    // Grant lock: hold the stalled master until its request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock      <= 1'b0;
            r_lock_data <= 1'b0;
        end else if (mem_req) begin
            r_lock      <= ~mem_addr_ok;
            r_lock_data <= w_sel_data;
        end
    end

    // Owner FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Owner FIFO storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_owner[r_wptr] <= w_sel_data;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUT, default 2, meaning max outstanding accepted-but-unanswered transactions (power of 2, 1..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port inst_req  input  1  fetch master read request.
REQ-005 SHALL have port inst_size  input  2  fetch access size.
REQ-006 SHALL have port inst_addr  input  32  fetch physical address.
REQ-007 SHALL have port inst_addr_ok  output  1  fetch request accepted.
REQ-008 SHALL have port inst_data_ok  output  1  fetch response valid.
REQ-009 SHALL have port inst_rdata  output  32  fetch read data.
REQ-010 SHALL have port data_req  input  1  execute-stage load/store request.
REQ-011 SHALL have port data_wr  input  1  1 = store.
REQ-012 SHALL have port data_size  input  2  access size.
REQ-013 SHALL have port data_wstrb  input  4  byte strobes.
REQ-014 SHALL have port data_addr  input  32  physical address.
REQ-015 SHALL have port data_wdata  input  32  store data.
REQ-016 SHALL have port data_addr_ok  output  1  data request accepted.
REQ-017 SHALL have port data_data_ok  output  1  data response valid.
REQ-018 SHALL have port data_rdata  output  32  load data.
REQ-019 SHALL have port mem_req  output  1  request to shared memory port.
REQ-020 SHALL have port mem_wr  output  1  forwarded write flag.
REQ-021 SHALL have port mem_size  output  2  forwarded size.
REQ-022 SHALL have port mem_wstrb  output  4  forwarded strobes.
REQ-023 SHALL have port mem_addr  output  32  forwarded address.
REQ-024 SHALL have port mem_wdata  output  32  forwarded write data.
REQ-025 SHALL have port mem_addr_ok  input  1  memory accepted request.
REQ-026 SHALL have port mem_data_ok  input  1  memory response valid, strictly in acceptance order.
REQ-027 SHALL have port mem_rdata  input  32  memory read data.

Function
REQ-028 Arbitration SHALL be fixed priority when unlocked: data over inst.
REQ-029 mem_req SHALL equal (selected master's req) AND NOT full AND NOT rst, where full = registered count == MAX_OUT.
REQ-030 Lock: if mem_req=1 and mem_addr_ok=0 in a cycle, grant SHALL stay with the same master next cycle irrespective of the other req; lock clears on the cycle mem_req&mem_addr_ok.
REQ-031 mem_wr/size/wstrb/addr/wdata SHALL be combinationally muxed from the granted master; for inst grant mem_wr=0, mem_wstrb=0, mem_wdata=0.
REQ-032 Granted master's addr_ok SHALL be mem_req&mem_addr_ok (zero-cycle); non-granted addr_ok SHALL be 0.
REQ-033 Owner FIFO (depth MAX_OUT, 1-bit ID: 0=inst, 1=data) SHALL push granted ID on mem_req&mem_addr_ok and pop on mem_data_ok when count>0.
REQ-034 mem_data_ok SHALL be routed combinationally to the FIFO-head owner's data_ok; other data_ok = 0; mem_rdata SHALL drive both inst_rdata and data_rdata unchanged.
REQ-035 Simultaneous push and pop SHALL leave count unchanged and preserve order; push when full SHALL be impossible (mem_req gated by registered full, pop in same cycle does not unblock).
REQ-036 mem_data_ok with count=0 SHALL be ignored: no data_ok asserted, no state change.
REQ-037 Pointers SHALL wrap modulo MAX_OUT; count width SHALL be clog2(MAX_OUT)+1.

Reset
REQ-038 While rst=1 at a clock edge: count=0, pointers=0, lock cleared; mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok SHALL be 0 during rst.
REQ-039 Reset mid-operation SHALL discard all outstanding owner entries; later mem_data_ok for them is ignored per REQ-036.

Verification
REQ-040 inst_req=data_req=1, mem_addr_ok=1, addr 0x1000/0x2000 -> mem_addr=0x2000, data_addr_ok=1, inst_addr_ok=0; next cycle mem_addr=0x1000, inst_addr_ok=1.
REQ-041 inst_req=1, mem_addr_ok=0 for 3 cycles, data_req rises cycle 1 -> mem_addr holds inst address until mem_addr_ok, then data granted.
REQ-042 MAX_OUT=2: accept inst then data, third request -> mem_req=0 until first mem_data_ok; first data_ok -> inst_data_ok=1, second -> data_data_ok=1.
REQ-043 count=1, accept and mem_data_ok same cycle -> count stays 1, response goes to older owner, next response to newer.
REQ-044 rst pulsed with 2 outstanding, then mem_data_ok=1 -> count=0, both data_ok=0, mem_req follows inputs next cycle.
